// File: rtl/usb_cmd_responder_pkg.sv
// Shared definitions for the USB command responder: opcodes, status codes,
// response frame header/length and the responder FSM state type.
package usb_cmd_defs;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WR_REG = 8'h01;
    localparam logic [7:0] OP_RD_REG = 8'h02;
    localparam logic [7:0] OP_START  = 8'h10;
    localparam logic [7:0] OP_STOP   = 8'h11;
    localparam logic [7:0] OP_PING   = 8'h55;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_ADDR = 8'h01;
    localparam logic [7:0] ST_UNKNOWN  = 8'h02;

    localparam logic [7:0]  FRAME_HDR = 8'hA5;
    localparam int unsigned FRAME_LEN = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SEND
    } state_t;

endpackage

// File: rtl/usb_cmd_responder_regbank.sv
// Control register bank: NREG x 16-bit, reg 0 is the read-only VERSION word.
// Single address port shared by the write path, the read mux and the address check.
module usb_cmd_regbank #(
    parameter int unsigned NREG    = 8,
    parameter logic [15:0] VERSION = 16'h0101
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [7:0]         addr,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata,
    output logic               addr_bad,
    output logic               wr_bad,
    output logic [NREG*16-1:0] regs_flat
);

    logic [15:0] regs_q [NREG-1:1];
    logic [15:0] regs_d [NREG-1:1];

    always_comb begin
        addr_bad = (32'(addr) >= NREG);
        wr_bad   = addr_bad || (addr == 8'd0);
    end

    always_comb begin
        regs_d = regs_q;
        if (we && !wr_bad) begin
            for (int unsigned k = 1; k < NREG; k++) begin
                if (32'(addr) == k) regs_d[k] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 1; k < NREG; k++) regs_q[k] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == 8'd0) rdata = VERSION;
        for (int unsigned k = 1; k < NREG; k++) begin
            if (32'(addr) == k) rdata = regs_q[k];
        end
    end

    always_comb begin
        regs_flat        = '0;
        regs_flat[15:0]  = VERSION;
        for (int unsigned k = 1; k < NREG; k++) regs_flat[k*16 +: 16] = regs_q[k];
    end

endmodule

// File: rtl/usb_cmd_responder.sv
// Host command executor: decodes one command, applies its side effect and
// streams a 4-word response frame into the upstream USB FIFO.
module usb_cmd_responder
    import usb_cmd_defs::*;
#(
    parameter int unsigned NREG    = 8,
    parameter logic [15:0] VERSION = 16'h0101
) (
    input  logic               i_clk_sys,
    input  logic               i_rst,
    input  logic               i_cmd_come,
    input  logic [7:0]         i_cmd,
    input  logic [31:0]        i_cmd_param,
    input  logic               i_full,
    output logic               o_wr,
    output logic [15:0]        o_wr_data,
    output logic [NREG*16-1:0] o_regs,
    output logic               o_acq_en,
    output logic               o_acq_start,
    output logic               o_busy,
    output logic [7:0]         o_drop_cnt
);

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] plo_q, plo_d;
    logic [7:0]  status_q, status_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  drop_q, drop_d;
    logic        acq_en_q, acq_en_d;
    logic        acq_start_q, acq_start_d;

    logic        reg_we;
    logic [15:0] reg_rdata;
    logic        addr_bad, wr_bad;

    usb_cmd_regbank #(
        .NREG    (NREG),
        .VERSION (VERSION)
    ) u_regbank (
        .clk       (i_clk_sys),
        .rst       (i_rst),
        .we        (reg_we),
        .addr      (addr_q),
        .wdata     (plo_q),
        .rdata     (reg_rdata),
        .addr_bad  (addr_bad),
        .wr_bad    (wr_bad),
        .regs_flat (o_regs)
    );

    assign o_wr        = (state_q == S_SEND) && !i_full;
    assign o_busy      = (state_q != S_IDLE);
    assign o_acq_en    = acq_en_q;
    assign o_acq_start = acq_start_q;
    assign o_drop_cnt  = drop_q;

    always_comb begin
        o_wr_data = '0;
        if (state_q == S_SEND) begin
            case (idx_q)
                2'd0:    o_wr_data = {FRAME_HDR, cmd_q};
                2'd1:    o_wr_data = {8'h00, status_q};
                2'd2:    o_wr_data = data_q;
                default: o_wr_data = {8'h00, seq_q};
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        plo_d       = plo_q;
        status_d    = status_q;
        data_d      = data_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        drop_d      = drop_q;
        acq_en_d    = acq_en_q;
        acq_start_d = 1'b0;
        reg_we      = 1'b0;

        // Strobes outside S_IDLE (including the final-word cycle) are dropped, never queued
        if (i_cmd_come && state_q != S_IDLE && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_come) begin
                    cmd_d   = i_cmd;
                    addr_d  = i_cmd_param[31:24];
                    plo_d   = i_cmd_param[15:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                status_d = ST_OK;
                data_d   = '0;
                case (cmd_q)
                    OP_NOP: ;
                    OP_WR_REG: begin
                        if (wr_bad) status_d = ST_BAD_ADDR;
                        else        reg_we   = 1'b1;
                    end
                    OP_RD_REG: begin
                        if (addr_bad) status_d = ST_BAD_ADDR;
                        else          data_d   = reg_rdata;
                    end
                    OP_START: begin
                        acq_en_d    = 1'b1;
                        acq_start_d = 1'b1;
                    end
                    OP_STOP: acq_en_d = 1'b0;
                    OP_PING: data_d   = plo_q;
                    default: status_d = ST_UNKNOWN;
                endcase
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (o_wr) begin
                    if (32'(idx_q) == FRAME_LEN - 1) begin
                        seq_d   = seq_q + 8'd1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            plo_q       <= '0;
            status_q    <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            seq_q       <= '0;
            drop_q      <= '0;
            acq_en_q    <= 1'b0;
            acq_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            plo_q       <= plo_d;
            status_q    <= status_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            drop_q      <= drop_d;
            acq_en_q    <= acq_en_d;
            acq_start_q <= acq_start_d;
        end
    end

endmodule

// File: tb/tb_usb_cmd_responder.sv
// Directed bench for usb_cmd_responder: expected frame words are queued by the
// stimulus and popped by an independent FIFO-write monitor.
module tb_usb_cmd_responder;

    localparam int unsigned NREG = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_come;
    logic [7:0]         cmd;
    logic [31:0]        cmd_param;
    logic               full;
    logic               wr;
    logic [15:0]        wr_data;
    logic [NREG*16-1:0] regs;
    logic               acq_en;
    logic               acq_start;
    logic               busy;
    logic [7:0]         drop_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    usb_cmd_responder #(
        .NREG    (NREG),
        .VERSION (16'h0101)
    ) dut (
        .i_clk_sys   (clk),
        .i_rst       (rst),
        .i_cmd_come  (cmd_come),
        .i_cmd       (cmd),
        .i_cmd_param (cmd_param),
        .i_full      (full),
        .o_wr        (wr),
        .o_wr_data   (wr_data),
        .o_regs      (regs),
        .o_acq_en    (acq_en),
        .o_acq_start (acq_start),
        .o_busy      (busy),
        .o_drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted FIFO write must match the next queued word
    initial begin
        forever begin
            @(negedge clk);
            if (wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {112'd0, wr_data}, 128'hDEAD_0000);
                end else begin
                    chk("frame_word", {112'd0, wr_data}, {112'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] w0, w1, w2, w3);
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        exp_q.push_back(w3);
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] param);
        cmd_come  = 1'b1;
        cmd       = op;
        cmd_param = param;
        tick();
        cmd_come  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, {127'd0, busy}, 128'd0);
        tick();
        chk({name, "_words_left"}, 128'(exp_q.size()), 128'd0);
    endtask

    function automatic logic [127:0] regs_exp(input logic [15:0] r3);
        logic [127:0] v = '0;
        v[15:0]  = 16'h0101;
        v[63:48] = r3;
        return v;
    endfunction

    initial begin
        rst       = 1'b1;
        cmd_come  = 1'b0;
        cmd       = '0;
        cmd_param = '0;
        full      = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_wr",        {127'd0, wr}, 128'd0);
        chk("rst_wr_data",   {112'd0, wr_data}, 128'd0);
        chk("rst_busy",      {127'd0, busy}, 128'd0);
        chk("rst_regs",      regs, regs_exp(16'h0000));
        chk("rst_acq",       {126'd0, acq_en, acq_start}, 128'd0);
        chk("rst_drop",      {120'd0, drop_cnt}, 128'd0);

        // 1: register write, visible at T+2 together with the first write
        push_frame(16'hA501, 16'h0000, 16'h0000, 16'h0000);
        issue(8'h01, 32'h0300_BEEF);
        chk("wr_t1_wr",   {127'd0, wr}, 128'd0);
        chk("wr_t1_reg3", {112'd0, regs[63:48]}, 128'd0);
        tick();
        chk("wr_t2_wr",   {127'd0, wr}, 128'd1);
        chk("wr_t2_reg3", {112'd0, regs[63:48]}, 128'hBEEF);
        wait_idle("wr_reg3");

        // 2: reads
        push_frame(16'hA502, 16'h0000, 16'hBEEF, 16'h0001);
        issue(8'h02, 32'h0300_0000);
        wait_idle("rd_reg3");
        push_frame(16'hA502, 16'h0000, 16'h0101, 16'h0002);
        issue(8'h02, 32'h0000_0000);
        wait_idle("rd_reg0");

        // 3: bad addresses
        push_frame(16'hA501, 16'h0001, 16'h0000, 16'h0003);
        issue(8'h01, 32'h0800_1111);
        wait_idle("wr_reg8");
        push_frame(16'hA501, 16'h0001, 16'h0000, 16'h0004);
        issue(8'h01, 32'h0000_2222);
        wait_idle("wr_reg0");
        chk("bad_wr_regs", regs, regs_exp(16'hBEEF));

        // 4: PING with FIFO back-pressure after the first word
        push_frame(16'hA555, 16'h0000, 16'h1234, 16'h0005);
        issue(8'h55, 32'h0000_1234);
        tick();
        chk("ping_w0_wr", {127'd0, wr}, 128'd1);
        tick();
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("stall_wr",   {127'd0, wr}, 128'd0);
            chk("stall_data", {112'd0, wr_data}, 128'h0000);
            tick();
        end
        full = 1'b0;
        wait_idle("ping_stall");

        // 5: START with a dropped follow-up strobe, STOP, unknown opcode
        push_frame(16'hA510, 16'h0000, 16'h0000, 16'h0006);
        issue(8'h10, 32'h0);
        issue(8'h00, 32'h0);
        chk("start_pulse", {127'd0, acq_start}, 128'd1);
        chk("start_en",    {127'd0, acq_en}, 128'd1);
        tick();
        chk("start_pulse_end", {127'd0, acq_start}, 128'd0);
        wait_idle("start");
        chk("drop_cnt", {120'd0, drop_cnt}, 128'd1);
        push_frame(16'hA511, 16'h0000, 16'h0000, 16'h0007);
        issue(8'h11, 32'h0);
        wait_idle("stop");
        chk("stop_en", {127'd0, acq_en}, 128'd0);
        push_frame(16'hA57E, 16'h0002, 16'h0000, 16'h0008);
        issue(8'h7E, 32'h0);
        wait_idle("unknown");

        // 6: reset mid-frame
        push_frame(16'hA510, 16'h0000, 16'h0000, 16'h0009);
        issue(8'h10, 32'h0);
        wait_idle("start2");
        exp_q.push_back(16'hA555);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h4321);
        issue(8'h55, 32'h0000_4321);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wr",    {127'd0, wr}, 128'd0);
        chk("midrst_busy",  {127'd0, busy}, 128'd0);
        chk("midrst_regs",  regs, regs_exp(16'h0000));
        chk("midrst_acq",   {127'd0, acq_en}, 128'd0);
        chk("midrst_drop",  {120'd0, drop_cnt}, 128'd0);
        tick();
        chk("midrst_words_left", 128'(exp_q.size()), 128'd0);
        push_frame(16'hA555, 16'h0000, 16'h0042, 16'h0000);
        issue(8'h55, 32'h0000_0042);
        wait_idle("ping_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
